// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// Defaults for width parameters, stack pointer slot, base typedefs.
package regfile_pkg;

    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_TAG_WIDTH  = 4;
    localparam int DEF_SP_INDEX   = 2;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [DEF_TAG_WIDTH-1:0]  reg_tag_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy/tag tracking with issue, flush and tagged writeback clear.
// Ports: issue_*, wb_*, flush in; rd_raw per read port, busy_vec out.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ-1:0]             rd_raw,
    input  logic                            issue_valid,
    input  logic [ADDR_WIDTH-1:0]           issue_rd,
    input  logic [TAG_WIDTH-1:0]            issue_tag,
    input  logic [NUM_WRITE-1:0]            wb_valid,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_WRITE*TAG_WIDTH-1:0]  wb_tag,
    input  logic                            flush,
    output logic [NUM_REGS-1:0]             busy_vec
);

    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [TAG_WIDTH-1:0] tag_q [NUM_REGS];
    logic [TAG_WIDTH-1:0] tag_d [NUM_REGS];

    logic [ADDR_WIDTH-1:0] ra [NUM_READ];
    logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
    logic [TAG_WIDTH-1:0]  wt [NUM_WRITE];
    logic [NUM_WRITE-1:0]  wb_en;
    logic [NUM_READ-1:0]   tag_hit;

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            ra[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int w = 0; w < NUM_WRITE; w++) begin
            wa[w]    = wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
            wt[w]    = wb_tag[w*TAG_WIDTH +: TAG_WIDTH];
            wb_en[w] = wb_valid[w] && (wa[w] != '0);
        end
    end

    // Later ports overwrite earlier ones, so the highest
    // port decides the clear. Issue is applied last so it
    // beats both flush and a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wb_en[w]) begin
                    busy_d[wa[w]] = busy_q[wa[w]] &&
                                    (tag_q[wa[w]] != wt[w]);
                end
            end
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    // A same-cycle writeback with the current tag resolves
    // the hazard; highest matching-address port decides.
    always_comb begin
        tag_hit = '0;
        rd_raw  = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wb_en[w] && (wa[w] == ra[i])) begin
                    tag_hit[i] = (wt[w] == tag_q[ra[i]]);
                end
            end
            rd_raw[i] = busy_q[ra[i]] && !tag_hit[i] &&
                        (ra[i] != '0);
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with scoreboard and wb-to-read bypass.
// Ports: rd_* async reads, issue_* reserve, wb_* retire, flush, status.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int SP_INDEX   = DEF_SP_INDEX,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           stackptr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]             rd_raw,
    output logic                            raw_dependency,
    input  logic                            issue_valid,
    input  logic [ADDR_WIDTH-1:0]           issue_rd,
    input  logic [TAG_WIDTH-1:0]            issue_tag,
    input  logic [NUM_WRITE-1:0]            wb_valid,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wb_data,
    input  logic [NUM_WRITE*TAG_WIDTH-1:0]  wb_tag,
    input  logic                            flush,
    output logic                            write_complete,
    output logic [NUM_REGS-1:0]             busy_vec
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic [ADDR_WIDTH-1:0] ra [NUM_READ];
    logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wd [NUM_WRITE];
    logic [DATA_WIDTH-1:0] rv [NUM_READ];
    logic [NUM_WRITE-1:0]  wb_en;

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            ra[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int w = 0; w < NUM_WRITE; w++) begin
            wa[w]    = wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
            wd[w]    = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
            wb_en[w] = wb_valid[w] && (wa[w] != '0);
        end
    end

    // Data lands regardless of tag; later ports win by
    // nonblocking-assignment order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= (r == SP_INDEX) ? stackptr : '0;
            end
            write_complete <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wb_en[w]) begin
                    regs_q[wa[w]] <= wd[w];
                end
            end
            write_complete <= |wb_en;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rv[i] = regs_q[ra[i]];
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wb_en[w] && (wa[w] == ra[i])) begin
                    rv[i] = wd[w];
                end
            end
            if (ra[i] == '0) begin
                rv[i] = '0;
            end
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = rv[i];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_raw      (rd_raw),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_tag   (issue_tag),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_tag      (wb_tag),
        .flush       (flush),
        .busy_vec    (busy_vec)
    );

    assign raw_dependency = |rd_raw;

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb.
// Expected read data is queued at drive time and popped on compare.
module tb_register_file_sb;
    import regfile_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int TW = DEF_TAG_WIDTH;

    logic            clk = 1'b0;
    logic            reset;
    reg_data_t       stackptr;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]      rd_raw;
    logic            raw_dependency;
    logic            issue_valid;
    reg_addr_t       issue_rd;
    reg_tag_t        issue_tag;
    logic [1:0]      wb_valid;
    logic [2*AW-1:0] wb_addr;
    logic [2*DW-1:0] wb_data;
    logic [2*TW-1:0] wb_tag;
    logic            flush;
    logic            write_complete;
    logic [31:0]     busy_vec;

    int        n_checks = 0;
    int        n_fail   = 0;
    reg_data_t exp_q[$];
    reg_data_t exp;
    logic [31:0] exp_busy;

    register_file_sb dut (
        .clk            (clk),
        .reset          (reset),
        .stackptr       (stackptr),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .rd_raw         (rd_raw),
        .raw_dependency (raw_dependency),
        .issue_valid    (issue_valid),
        .issue_rd       (issue_rd),
        .issue_tag      (issue_tag),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_tag         (wb_tag),
        .flush          (flush),
        .write_complete (write_complete),
        .busy_vec       (busy_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_tag   = '0;
        wb_valid    = '0;
        wb_addr     = '0;
        wb_data     = '0;
        wb_tag      = '0;
        flush       = 1'b0;
        rd_addr     = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input int p, input reg_addr_t a,
                          input reg_tag_t t, input reg_data_t d);
        wb_valid[p]         = 1'b1;
        wb_addr[p*AW +: AW] = a;
        wb_tag[p*TW +: TW]  = t;
        wb_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input reg_addr_t a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic test_reset();
        idle();
        stackptr = 64'h8000_0000;
        reset    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        set_rd(0, 5'd2);
        set_rd(1, 5'd0);
        exp_q.push_back(64'h8000_0000);
        exp_q.push_back(64'h0);
        #2;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL reset_sp: got %h want %h", rd_data[63:0], exp);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[127:64] !== exp) begin
            n_fail++;
            $display("FAIL reset_r0: got %h want %h", rd_data[127:64], exp);
        end
        n_checks++;
        if (busy_vec !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_busy: got %h want 0", busy_vec);
        end
        n_checks++;
        if (write_complete !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wc: got %b want 0", write_complete);
        end
    endtask

    task automatic test_raw_bypass();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        issue_tag   = 4'd3;
        tick();
        idle();
        set_rd(0, 5'd5);
        #2;
        n_checks++;
        if (rd_raw[0] !== 1'b1 || raw_dependency !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_set: got raw=%b dep=%b want 1 1",
                     rd_raw[0], raw_dependency);
        end
        set_wb(0, 5'd5, 4'd3, 64'hAB);
        exp_q.push_back(64'hAB);
        #2;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL bypass: got %h want %h", rd_data[63:0], exp);
        end
        n_checks++;
        if (rd_raw[0] !== 1'b0 || raw_dependency !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_resolve: got raw=%b dep=%b want 0 0",
                     rd_raw[0], raw_dependency);
        end
        tick();
        wb_valid = '0;
        exp_q.push_back(64'hAB);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL reg5: got %h want %h", rd_data[63:0], exp);
        end
        n_checks++;
        if (busy_vec[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy5_clr: got %b want 0", busy_vec[5]);
        end
        n_checks++;
        if (write_complete !== 1'b1) begin
            n_fail++;
            $display("FAIL wc_pulse: got %b want 1", write_complete);
        end
        tick();
        n_checks++;
        if (write_complete !== 1'b0) begin
            n_fail++;
            $display("FAIL wc_drop: got %b want 0", write_complete);
        end
    endtask

    task automatic test_tag_mismatch();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        issue_tag   = 4'd1;
        tick();
        issue_tag = 4'd2;
        tick();
        idle();
        set_rd(0, 5'd7);
        set_wb(0, 5'd7, 4'd1, 64'h11);
        #2;
        n_checks++;
        if (rd_raw[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_raw: got %b want 1", rd_raw[0]);
        end
        tick();
        wb_valid = '0;
        exp_q.push_back(64'h11);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL stale_data: got %h want %h", rd_data[63:0], exp);
        end
        n_checks++;
        if (busy_vec[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_busy: got %b want 1", busy_vec[7]);
        end
        set_wb(0, 5'd7, 4'd2, 64'h22);
        #2;
        n_checks++;
        if (rd_raw[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL new_raw: got %b want 0", rd_raw[0]);
        end
        tick();
        wb_valid = '0;
        exp_q.push_back(64'h22);
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL new_data: got %h want %h", rd_data[63:0], exp);
        end
        n_checks++;
        if (busy_vec[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL new_busy: got %b want 0", busy_vec[7]);
        end
    endtask

    task automatic test_multi_wb();
        idle();
        set_wb(0, 5'd9, 4'd0, 64'h1);
        set_wb(1, 5'd9, 4'd0, 64'h2);
        set_rd(1, 5'd9);
        exp_q.push_back(64'h2);
        exp_q.push_back(64'h2);
        #2;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[127:64] !== exp) begin
            n_fail++;
            $display("FAIL multi_byp: got %h want %h", rd_data[127:64], exp);
        end
        tick();
        wb_valid = '0;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[127:64] !== exp) begin
            n_fail++;
            $display("FAIL multi_reg: got %h want %h", rd_data[127:64], exp);
        end
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        issue_tag   = 4'd5;
        tick();
        idle();
        set_rd(0, 5'd10);
        set_wb(0, 5'd10, 4'd5, 64'hA0);
        set_wb(1, 5'd10, 4'd4, 64'hA1);
        exp_q.push_back(64'hA1);
        #2;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL hi_byp: got %h want %h", rd_data[63:0], exp);
        end
        n_checks++;
        if (rd_raw[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL hi_raw: got %b want 1", rd_raw[0]);
        end
        tick();
        wb_valid = '0;
        n_checks++;
        if (busy_vec[10] !== 1'b1) begin
            n_fail++;
            $display("FAIL hi_busy: got %b want 1", busy_vec[10]);
        end
    endtask

    task automatic test_issue_wb_flush();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        issue_tag   = 4'd6;
        set_wb(0, 5'd4, 4'd0, 64'h44);
        tick();
        idle();
        set_rd(0, 5'd4);
        exp_q.push_back(64'h44);
        #2;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL iw_data: got %h want %h", rd_data[63:0], exp);
        end
        n_checks++;
        if (busy_vec[4] !== 1'b1 || rd_raw[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL iw_busy: got busy=%b raw=%b want 1 1",
                     busy_vec[4], rd_raw[0]);
        end
        set_wb(0, 5'd4, 4'd6, 64'h46);
        #2;
        n_checks++;
        if (rd_raw[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL iw_tag6: got %b want 0", rd_raw[0]);
        end
        tick();
        wb_valid = '0;
        n_checks++;
        if (busy_vec[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL iw_clr: got %b want 0", busy_vec[4]);
        end
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        issue_tag   = 4'd2;
        tick();
        flush     = 1'b1;
        issue_rd  = 5'd8;
        issue_tag = 4'd1;
        tick();
        idle();
        exp_busy    = '0;
        exp_busy[8] = 1'b1;
        n_checks++;
        if (busy_vec !== exp_busy) begin
            n_fail++;
            $display("FAIL flush: got %h want %h", busy_vec, exp_busy);
        end
    endtask

    task automatic test_reg_zero();
        idle();
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        issue_tag   = 4'd3;
        set_wb(0, 5'd0, 4'd3, 64'hFF);
        set_rd(0, 5'd0);
        exp_q.push_back(64'h0);
        #2;
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp || rd_raw[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_read: got %h raw=%b want %h raw=0",
                     rd_data[63:0], rd_raw[0], exp);
        end
        tick();
        idle();
        n_checks++;
        if (write_complete !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_wc: got %b want 0", write_complete);
        end
        n_checks++;
        if (busy_vec !== exp_busy) begin
            n_fail++;
            $display("FAIL r0_busy: got %h want %h", busy_vec, exp_busy);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        stackptr    = 64'h1234;
        reset       = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        issue_tag   = 4'd1;
        set_wb(0, 5'd3, 4'd1, 64'h33);
        tick();
        reset = 1'b1;
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd2);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1234);
        #2;
        n_checks++;
        if (busy_vec !== 32'h0 || write_complete !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got busy=%h wc=%b want 0 0",
                     busy_vec, write_complete);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[63:0] !== exp) begin
            n_fail++;
            $display("FAIL mid_r3: got %h want %h", rd_data[63:0], exp);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (rd_data[127:64] !== exp) begin
            n_fail++;
            $display("FAIL mid_sp: got %h want %h", rd_data[127:64], exp);
        end
    endtask

    initial begin
        reset    = 1'b0;
        stackptr = '0;
        idle();
        test_reset();
        test_raw_bypass();
        test_tag_mismatch();
        test_multi_wb();
        test_issue_wb_flush();
        test_reg_zero();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d left want 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
